// File: rtl/sd_loader_pkg.sv
// Shared definitions for the SD sector loader: FSM encoding and sector geometry.
package sd_loader_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int BYTE_CNT_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_RECV,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/sd_strobe_edge.sv
// Registers the SD controller's level byte strobe, flags its rising edge and holds
// the byte that was presented when the strobe rose.
module sd_strobe_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe_i,
    input  logic [7:0] data_i,
    output logic       edge_o,
    output logic [7:0] data_o
);

    logic       level_q;
    logic       prev_q;
    logic [7:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            level_q <= strobe_i;
            prev_q  <= level_q;
            if (strobe_i && !level_q) begin
                data_q <= data_i;
            end
        end
    end

    assign edge_o = level_q & ~prev_q;
    assign data_o = data_q;

endmodule

// File: rtl/sd_rom_loader.sv
// Bulk sector-read sequencer: streams N SD sectors into cart RAM with per-sector retry.
// Optional SD_LOADER_CHECKSUM_EN adds a 16-bit running checksum output of written bytes.
module sd_rom_loader
    import sd_loader_pkg::*;
#(
    parameter int MEM_AW        = 17,
    parameter int MAX_RETRIES   = 3,
    parameter int READY_TIMEOUT = 1 << 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       start_sector,
    input  logic [15:0]       num_sectors,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    input  logic              sd_ready,
    input  logic              sd_byte_available,
    input  logic [7:0]        sd_dout,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata
`ifdef SD_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int TIMER_W = 25;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [TIMER_W-1:0]    TIMEOUT_LAST = TIMER_W'(READY_TIMEOUT - 1);
    localparam logic [BYTE_CNT_W-1:0] FULL_SECTOR  = BYTE_CNT_W'(SECTOR_BYTES);
    localparam logic [RETRY_W-1:0]    RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t                state_q, state_d;
    logic [31:0]           start_sector_q, start_sector_d;
    logic [15:0]           num_sectors_q, num_sectors_d;
    logic [15:0]           sector_cnt_q, sector_cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic [MEM_AW-1:0]     base_q, base_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  error_q, error_d;
    logic [31:0]           sd_address_q, sd_address_d;
    logic                  we_q, we_d;
    logic [MEM_AW-1:0]     waddr_q, waddr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  busy_q, done_q, sd_rd_q;
    logic                  byte_edge;
    logic [7:0]            byte_data;
    logic                  timeout;
`ifdef SD_LOADER_CHECKSUM_EN
    logic [15:0]           sum_q, sum_d, sec_sum_q, sec_sum_d;
`endif

    sd_strobe_edge u_strobe (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (sd_byte_available),
        .data_i   (sd_dout),
        .edge_o   (byte_edge),
        .data_o   (byte_data)
    );

    assign timeout = (timer_q == TIMEOUT_LAST);

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        start_sector_d = start_sector_q;
        num_sectors_d  = num_sectors_q;
        sector_cnt_d   = sector_cnt_q;
        retry_d        = retry_q;
        byte_cnt_d     = byte_cnt_q;
        overflow_d     = overflow_q;
        addr_d         = addr_q;
        base_d         = base_q;
        error_d        = error_q;
        sd_address_d   = sd_address_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        timer_d        = timer_q + TIMER_W'(1);
`ifdef SD_LOADER_CHECKSUM_EN
        sum_d          = sum_q;
        sec_sum_d      = sec_sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_sector_d = start_sector;
                    num_sectors_d  = num_sectors;
                    error_d        = 1'b0;
                    sector_cnt_d   = '0;
                    retry_d        = '0;
                    byte_cnt_d     = '0;
                    overflow_d     = 1'b0;
                    addr_d         = '0;
                    base_d         = '0;
`ifdef SD_LOADER_CHECKSUM_EN
                    sum_d          = '0;
                    sec_sum_d      = '0;
`endif
                    state_d = (num_sectors == 16'd0) ? ST_DONE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (sd_ready) begin
                    sd_address_d = start_sector_q + 32'(sector_cnt_q);
                    state_d      = ST_ISSUE;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ISSUE: begin
                if (!sd_ready) begin
                    state_d = ST_RECV;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RECV: begin
                if (byte_edge) begin
                    timer_d = '0;
                    // Surplus bytes are dropped and turn the sector into a failed read.
                    if (byte_cnt_q == FULL_SECTOR) begin
                        overflow_d = 1'b1;
                    end else begin
                        we_d       = 1'b1;
                        waddr_d    = addr_q;
                        wdata_d    = byte_data;
                        addr_d     = addr_q + 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef SD_LOADER_CHECKSUM_EN
                        sum_d      = sum_q + 16'(byte_data);
                        sec_sum_d  = sec_sum_q + 16'(byte_data);
`endif
                    end
                end
                if (sd_ready) begin
                    state_d = ST_CHECK;
                end else if (timeout && !byte_edge) begin
                    state_d = ST_ERROR;
                end
            end
            ST_CHECK: begin
                byte_cnt_d = '0;
                overflow_d = 1'b0;
`ifdef SD_LOADER_CHECKSUM_EN
                sec_sum_d  = '0;
`endif
                if (byte_cnt_q == FULL_SECTOR && !overflow_q) begin
                    sector_cnt_d = sector_cnt_q + 16'd1;
                    retry_d      = '0;
                    base_d       = addr_q;
                    state_d      = (sector_cnt_q + 16'd1 == num_sectors_q) ? ST_DONE : ST_WAIT_RDY;
                end else begin
                    addr_d  = base_q;
                    retry_d = retry_q + RETRY_W'(1);
`ifdef SD_LOADER_CHECKSUM_EN
                    sum_d   = sum_q - sec_sum_q;
`endif
                    state_d = (retry_q + RETRY_W'(1) == RETRY_LIMIT) ? ST_ERROR : ST_WAIT_RDY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            start_sector_q <= '0;
            num_sectors_q  <= '0;
            sector_cnt_q   <= '0;
            retry_q        <= '0;
            byte_cnt_q     <= '0;
            overflow_q     <= 1'b0;
            addr_q         <= '0;
            base_q         <= '0;
            timer_q        <= '0;
            error_q        <= 1'b0;
            sd_address_q   <= '0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sd_rd_q        <= 1'b0;
`ifdef SD_LOADER_CHECKSUM_EN
            sum_q          <= '0;
            sec_sum_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            start_sector_q <= start_sector_d;
            num_sectors_q  <= num_sectors_d;
            sector_cnt_q   <= sector_cnt_d;
            retry_q        <= retry_d;
            byte_cnt_q     <= byte_cnt_d;
            overflow_q     <= overflow_d;
            addr_q         <= addr_d;
            base_q         <= base_d;
            timer_q        <= timer_d;
            error_q        <= error_d;
            sd_address_q   <= sd_address_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            // Status lags state by one cycle so busy drops exactly when done or error rises.
            busy_q         <= (state_d != ST_IDLE);
            done_q         <= (state_q == ST_DONE);
            sd_rd_q        <= (state_d == ST_ISSUE);
`ifdef SD_LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
            sec_sum_q      <= sec_sum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign sd_rd      = sd_rd_q;
    assign sd_address = sd_address_q;
    assign mem_we     = we_q;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wdata_q;
`ifdef SD_LOADER_CHECKSUM_EN
    assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_sd_rom_loader.sv
// Self-checking bench for sd_rom_loader: behavioural SD controller plus a write/address scoreboard.
module tb_sd_rom_loader;

    localparam int MEM_AW = 17;
    localparam int TMO    = 40;

    logic              clk = 1'b0;
    logic              reset, start, busy, done, error, sd_rd;
    logic [31:0]       start_sector, sd_address;
    logic [15:0]       num_sectors;
    logic              sd_ready, sd_byte_available, mem_we;
    logic [7:0]        sd_dout, mem_wdata;
    logic [MEM_AW-1:0] mem_addr;
`ifdef SD_LOADER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    sd_rom_loader #(.MEM_AW(MEM_AW), .MAX_RETRIES(3), .READY_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_sector      (start_sector),
        .num_sectors       (num_sectors),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .sd_rd             (sd_rd),
        .sd_address        (sd_address),
        .sd_ready          (sd_ready),
        .sd_byte_available (sd_byte_available),
        .sd_dout           (sd_dout),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata)
`ifdef SD_LOADER_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s, expected none", name, what);
    endtask

    typedef struct {
        logic [MEM_AW-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_sd[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    logic        rd_prev = 1'b0;
    int          model_ptr = 0;
    logic [15:0] model_sum = '0;

    // Scoreboard: every RAM write and every new read command is matched against the model.
    always @(negedge clk) begin
        wr_t w;
        if (mem_we) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                fail("unexpected_write", $sformatf("write addr 0x%0h", mem_addr));
            end else begin
                w = exp_wr.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(w.addr));
                check("mem_wdata", 32'(mem_wdata), 32'(w.data));
            end
        end
        if (sd_rd && !rd_prev) begin
            rd_cnt++;
            if (exp_sd.size() == 0) begin
                fail("unexpected_sd_rd", $sformatf("read addr 0x%0h", sd_address));
            end else begin
                check("sd_address", sd_address, exp_sd.pop_front());
            end
        end
        rd_prev = sd_rd;
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] sec, input logic [15:0] n);
        start_sector = sec;
        num_sectors  = n;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int waited;
        waited = 0;
        while (!sd_rd && waited < 200) begin
            tick(1);
            waited++;
        end
        check(name, 32'(sd_rd), 32'd1);
    endtask

    // Behavioural controller: answers one read with nbytes strobes, then returns ready.
    task automatic serve(input int nbytes, input logic [7:0] pat, input bit const_data);
        logic [7:0]  d;
        logic [15:0] s;
        s = '0;
        wait_rd("sd_rd_seen");
        tick(2);
        sd_ready = 1'b0;
        tick(4);
        for (int i = 0; i < nbytes; i++) begin
            d = const_data ? pat : (8'(i) ^ pat);
            if (i < 512) begin
                exp_wr.push_back('{addr: MEM_AW'(model_ptr + i), data: d});
                s = s + 16'(d);
            end
            sd_dout           = d;
            sd_byte_available = 1'b1;
            tick(3);
            sd_byte_available = 1'b0;
            tick(2);
        end
        tick(3);
        sd_ready = 1'b1;
        if (nbytes == 512) begin
            model_ptr = model_ptr + 512;
            model_sum = model_sum + s;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick(1);
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        check({tag, "_sd_address"}, sd_address, 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, rd0, dn0, n;
        reset = 1'b1; start = 1'b0; start_sector = '0; num_sectors = '0;
        sd_ready = 1'b1; sd_byte_available = 1'b0; sd_dout = '0;
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        tick(2);

        // Two clean sectors; a second start while busy must be ignored.
        model_ptr = 0; model_sum = '0;
        wr0 = wr_cnt; dn0 = done_cnt;
        exp_sd.push_back(32'h100); exp_sd.push_back(32'h101);
        pulse_start(32'h100, 16'd2);
        check("t1_busy", 32'(busy), 32'd1);
        pulse_start(32'h555, 16'd0);
        serve(512, 8'h00, 1'b0);
        serve(512, 8'h00, 1'b0);
        wait_done("t1_done");
        check("t1_error", 32'(error), 32'd0);
        check("t1_final_addr", 32'(mem_addr), 32'd1023);
        tick(2);
        check("t1_writes", 32'(wr_cnt - wr0), 32'd1024);
        check("t1_done_count", 32'(done_cnt - dn0), 32'd1);
        check("t1_sd_queue", 32'(exp_sd.size()), 32'd0);
`ifdef SD_LOADER_CHECKSUM_EN
        check("t1_checksum", 32'(checksum), 32'(model_sum));
`endif

        // Sector that never delivers data: three attempts then sticky error, no done.
        model_ptr = 0; model_sum = '0;
        rd0 = rd_cnt; dn0 = done_cnt;
        repeat (3) exp_sd.push_back(32'h300);
        pulse_start(32'h300, 16'd1);
        repeat (3) serve(0, 8'h00, 1'b0);
        n = 0;
        while (!error && n < 200) begin
            tick(1);
            n++;
        end
        check("t4_error", 32'(error), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        tick(5);
        check("t4_error_sticky", 32'(error), 32'd1);
        check("t4_attempts", 32'(rd_cnt - rd0), 32'd3);
        check("t4_no_done", 32'(done_cnt - dn0), 32'd0);

        // Zero sectors: done two cycles after the start cycle, error cleared, no SD traffic.
        rd0 = rd_cnt;
        pulse_start(32'h700, 16'd0);
        check("t2_done_early", 32'(done), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        tick(1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy_low", 32'(busy), 32'd0);
        check("t2_error_cleared", 32'(error), 32'd0);
        tick(3);
        check("t2_no_sd_rd", 32'(rd_cnt - rd0), 32'd0);

        // Short second sector is rewound and re-read from the same block.
        model_ptr = 0; model_sum = '0;
        wr0 = wr_cnt;
        exp_sd.push_back(32'h100); exp_sd.push_back(32'h101); exp_sd.push_back(32'h101);
        pulse_start(32'h100, 16'd2);
        serve(512, 8'h00, 1'b0);
        serve(200, 8'hA5, 1'b0);
        serve(512, 8'h00, 1'b0);
        wait_done("t3_done");
        check("t3_error", 32'(error), 32'd0);
        check("t3_final_addr", 32'(mem_addr), 32'd1023);
        tick(2);
        check("t3_writes", 32'(wr_cnt - wr0), 32'd1224);
`ifdef SD_LOADER_CHECKSUM_EN
        check("t3_checksum_model", 32'(checksum), 32'(model_sum));
        check("t3_checksum_literal", 32'(checksum), 32'h0000FE00);
`endif

        // 513 strobes: surplus byte dropped, sector fails and is re-read.
        model_ptr = 0; model_sum = '0;
        wr0 = wr_cnt;
        exp_sd.push_back(32'h200); exp_sd.push_back(32'h200);
        pulse_start(32'h200, 16'd1);
        serve(513, 8'h00, 1'b0);
        serve(512, 8'h3C, 1'b0);
        wait_done("t5_done");
        check("t5_final_addr", 32'(mem_addr), 32'd511);
        tick(2);
        check("t5_writes", 32'(wr_cnt - wr0), 32'd1024);
        check("t5_queue", 32'(exp_wr.size()), 32'd0);

`ifdef SD_LOADER_CHECKSUM_EN
        // All-0xFF sector with a failed partial attempt first: partial bytes must not count.
        model_ptr = 0; model_sum = '0;
        exp_sd.push_back(32'h600); exp_sd.push_back(32'h600);
        pulse_start(32'h600, 16'd1);
        serve(300, 8'hFF, 1'b1);
        serve(512, 8'hFF, 1'b1);
        wait_done("t6_done");
        check("t6_checksum_literal", 32'(checksum), 32'h0000FE00);
        check("t6_checksum_model", 32'(checksum), 32'(model_sum));
        tick(2);
`endif

        // Controller never ready: error after the ready timeout, no read issued.
        rd0 = rd_cnt;
        sd_ready = 1'b0;
        pulse_start(32'h400, 16'd1);
        n = 1;
        while (!error && n < 200) begin
            tick(1);
            n++;
        end
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_window", 32'(n >= TMO && n <= TMO + 4), 32'd1);
        check("tmo_no_sd_rd", 32'(rd_cnt - rd0), 32'd0);
        sd_ready = 1'b1;
        tick(3);

        // Reset in the middle of receiving a sector.
        model_ptr = 0; model_sum = '0;
        wr0 = wr_cnt;
        exp_sd.push_back(32'h500);
        pulse_start(32'h500, 16'd1);
        wait_rd("t7_sd_rd");
        tick(2);
        sd_ready = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            exp_wr.push_back('{addr: MEM_AW'(i), data: 8'(i)});
            sd_dout = 8'(i);
            sd_byte_available = 1'b1;
            tick(3);
            sd_byte_available = 1'b0;
            tick(2);
        end
        check("t7_busy_before_reset", 32'(busy), 32'd1);
        sd_dout = 8'h77;
        sd_byte_available = 1'b1;
        reset = 1'b1;
        tick(1);
        check_outputs_zero("midreset");
        reset = 1'b0;
        tick(3);
        sd_byte_available = 1'b0;
        sd_ready = 1'b1;
        tick(20);
        check("t7_writes", 32'(wr_cnt - wr0), 32'd10);
        check("t7_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
